// File: rtl/sqrt_loop_sequencer.sv
// Control sequencer for the iterative square-root op-amp loop: picks a gain,
// clears and restarts the analog-style datapath, and waits for its output to settle.
module sqrt_loop_sequencer #(
   parameter int C_WIDTH    = 16,
   parameter int FLUSH_CYC  = 4,
   parameter int STABLE_CNT = 8,
   parameter int MAX_ITER   = 1023,
   parameter int ITER_W     = 10
) (
   input  logic               clk_100k,
   input  logic               reset_n,
   input  logic               req_valid,
   input  logic [C_WIDTH-1:0] req_value,
   output logic               req_ready,
   output logic [C_WIDTH-1:0] dp_value,
   output logic [31:0]        dp_gain,
   output logic               dp_clr_n,
   input  logic [31:0]        dp_loop_out,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [31:0]        res_data,
   output logic               res_timeout,
   output logic [ITER_W-1:0]  res_iter,
   output logic               busy
);

   localparam int FLUSH_W  = $clog2(FLUSH_CYC + 1);
   localparam int STABLE_W = $clog2(STABLE_CNT + 1);

   localparam logic [31:0] GAIN_UNITY = 32'h3F800000;
   localparam logic [31:0] GAIN_270   = 32'h43870000;
   localparam logic [31:0] GAIN_100   = 32'h42C80000;
   localparam logic [31:0] GAIN_50    = 32'h42480000;
   localparam logic [31:0] GAIN_10    = 32'h41200000;
   localparam logic [31:0] SQRT_36    = 32'h40C00000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_FLUSH,
      S_RUN,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [C_WIDTH-1:0]  dp_value_q, dp_value_d;
   logic [31:0]         dp_gain_q, dp_gain_d;
   logic                dp_clr_n_q, dp_clr_n_d;
   logic                req_ready_q, req_ready_d;
   logic                busy_q, busy_d;
   logic                res_valid_q, res_valid_d;
   logic [31:0]         res_data_q, res_data_d;
   logic                res_timeout_q, res_timeout_d;
   logic [ITER_W-1:0]   res_iter_q, res_iter_d;
   logic [FLUSH_W-1:0]  flush_q, flush_d;
   logic [ITER_W-1:0]   iter_q, iter_d;
   logic [STABLE_W-1:0] stable_q, stable_d;
   logic [31:0]         prev_q, prev_d;
   logic                have_prev_q, have_prev_d;

   logic                sample_eq;
   logic [STABLE_W-1:0] stable_inc;
   logic                converged;

   always_ff @(posedge clk_100k or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         dp_value_q    <= '0;
         dp_gain_q     <= GAIN_UNITY;
         dp_clr_n_q    <= 1'b0;
         req_ready_q   <= 1'b1;
         busy_q        <= 1'b0;
         res_valid_q   <= 1'b0;
         res_data_q    <= '0;
         res_timeout_q <= 1'b0;
         res_iter_q    <= '0;
         flush_q       <= '0;
         iter_q        <= '0;
         stable_q      <= '0;
         prev_q        <= '0;
         have_prev_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         dp_value_q    <= dp_value_d;
         dp_gain_q     <= dp_gain_d;
         dp_clr_n_q    <= dp_clr_n_d;
         req_ready_q   <= req_ready_d;
         busy_q        <= busy_d;
         res_valid_q   <= res_valid_d;
         res_data_q    <= res_data_d;
         res_timeout_q <= res_timeout_d;
         res_iter_q    <= res_iter_d;
         flush_q       <= flush_d;
         iter_q        <= iter_d;
         stable_q      <= stable_d;
         prev_q        <= prev_d;
         have_prev_q   <= have_prev_d;
      end
   end

   // The first RUN sample has nothing to compare against, so it never counts as stable.
   always_comb begin
      sample_eq  = have_prev_q && (dp_loop_out == prev_q);
      stable_inc = '0;
      if (sample_eq) begin
         stable_inc = (stable_q == {STABLE_W{1'b1}}) ? stable_q : stable_q + 1'b1;
      end
      converged = (stable_inc == STABLE_W'(STABLE_CNT - 1));
   end

   always_comb begin
      state_d       = state_q;
      dp_value_d    = dp_value_q;
      dp_gain_d     = dp_gain_q;
      res_data_d    = res_data_q;
      res_timeout_d = res_timeout_q;
      res_iter_d    = res_iter_q;
      flush_d       = flush_q;
      iter_d        = iter_q;
      stable_d      = stable_q;
      prev_d        = prev_q;
      have_prev_d   = have_prev_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               dp_value_d = req_value;
               state_d    = S_LOAD;
            end
         end
         S_LOAD: begin
            if (dp_value_q <= C_WIDTH'(100)) begin
               dp_gain_d = GAIN_270;
            end else if (dp_value_q <= C_WIDTH'(500)) begin
               dp_gain_d = GAIN_100;
            end else if (dp_value_q >= C_WIDTH'(2400)) begin
               dp_gain_d = GAIN_10;
            end else begin
               dp_gain_d = GAIN_50;
            end
            if (dp_value_q == '0 || dp_value_q == C_WIDTH'(36)) begin
               res_data_d    = (dp_value_q == '0) ? 32'h0000_0000 : SQRT_36;
               res_iter_d    = '0;
               res_timeout_d = 1'b0;
               state_d       = S_DONE;
            end else begin
               flush_d = '0;
               state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            if (flush_q == FLUSH_W'(FLUSH_CYC - 1)) begin
               iter_d      = ITER_W'(1);
               stable_d    = '0;
               have_prev_d = 1'b0;
               state_d     = S_RUN;
            end else begin
               flush_d = flush_q + 1'b1;
            end
         end
         S_RUN: begin
            prev_d      = dp_loop_out;
            have_prev_d = 1'b1;
            stable_d    = stable_inc;
            // Convergence is checked first so it wins over a simultaneous timeout.
            if (converged) begin
               res_data_d    = dp_loop_out;
               res_timeout_d = 1'b0;
               res_iter_d    = iter_q;
               state_d       = S_DONE;
            end else if (iter_q == ITER_W'(MAX_ITER)) begin
               res_data_d    = dp_loop_out;
               res_timeout_d = 1'b1;
               res_iter_d    = iter_q;
               state_d       = S_DONE;
            end else if (iter_q != {ITER_W{1'b1}}) begin
               iter_d = iter_q + 1'b1;
            end
         end
         S_DONE: begin
            if (res_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      req_ready_d = (state_d == S_IDLE);
      busy_d      = (state_d != S_IDLE);
      dp_clr_n_d  = (state_d == S_RUN);
      res_valid_d = (state_d == S_DONE);
   end

   assign req_ready   = req_ready_q;
   assign dp_value    = dp_value_q;
   assign dp_gain     = dp_gain_q;
   assign dp_clr_n    = dp_clr_n_q;
   assign res_valid   = res_valid_q;
   assign res_data    = res_data_q;
   assign res_timeout = res_timeout_q;
   assign res_iter    = res_iter_q;
   assign busy        = busy_q;

endmodule

// File: doc/sqrt_loop_sequencer.md
Name: sqrt_loop_sequencer

Overview:
- Sequences the iterative square-root op-amp loop: x → subtract y² → gain multiply → IIR filter → y.
- Accepts one integer operand at a time over a valid/ready handshake.
- Picks the loop gain for the operand's range, clears and restarts the loop, then watches the IEEE-754 loop output until it settles or a timeout expires.
- Presents the settled result over a second valid/ready handshake. Sits between the sample source and the op-amp datapath, in the clk_100k domain.

Parameters:
- C_WIDTH, 16, operand width (unsigned integer).
- FLUSH_CYC, 4, cycles the datapath clear is held asserted before a run.
- STABLE_CNT, 8, consecutive identical loop outputs that count as converged (≥2).
- MAX_ITER, 1023, run-cycle limit before timeout (fits ITER_W bits).
- ITER_W, 10, width of the iteration counter.

Ports:
- clk_100k, in, 1, loop clock.
- reset_n, in, 1, asynchronous active-low reset.
- req_valid, in, 1, operand offered.
- req_value, in, C_WIDTH, operand.
- req_ready, out, 1, block can accept an operand.
- dp_value, out, C_WIDTH, registered operand driven to the datapath non-inverting input.
- dp_gain, out, 32, IEEE-754 single gain for the datapath multiplier.
- dp_clr_n, out, 1, active-low synchronous clear request to the datapath registers.
- dp_loop_out, in, 32, IEEE-754 filter output from the datapath.
- res_valid, out, 1, result available.
- res_data, out, 32, IEEE-754 square-root result.
- res_timeout, out, 1, result was taken at MAX_ITER without convergence.
- res_iter, out, ITER_W, run cycles consumed.
- busy, out, 1, high in any state other than IDLE.

Behaviour:
Interface
- Reset: reset_n asynchronous, active-low; clock: clk_100k.

Reset values
- Outputs: req_ready=1, dp_value=0, dp_gain=0x3F800000, dp_clr_n=0, res_valid=0, res_data=0, res_timeout=0, res_iter=0, busy=0.
- State: IDLE.
- Reset asserted in any state aborts the operation immediately; no result is produced.

States
- IDLE, LOAD, FLUSH, RUN, DONE. All outputs are registered.

IDLE
- req_ready=1, dp_clr_n=0.
- On req_valid & req_ready: capture req_value into dp_value and go to LOAD. req_ready drops the following cycle.

LOAD (1 cycle)
- Register dp_gain from dp_value:
  - value ≤100 → 0x43870000 (270)
  - value ≤500 → 0x42C80000 (100)
  - value ≥2400 → 0x41200000 (10)
  - otherwise → 0x42480000 (50)
- Bypass cases go straight to DONE with res_iter=0 and res_timeout=0:
  - value==0 → res_data 0x00000000
  - value==36 → res_data 0x40C00000
- Otherwise clear the flush counter and go to FLUSH.

FLUSH
- Hold dp_clr_n=0 for exactly FLUSH_CYC cycles, then go to RUN.

RUN
- dp_clr_n=1. The iteration counter increments every cycle, starting at 1 on the first RUN cycle.
- Each cycle, compare dp_loop_out to the previous sample (all 32 bits):
  - Equal → stable counter increments.
  - Not equal → stable counter resets to 0.
  - The first RUN cycle has no previous sample and never counts as equal.
- Converged: stable counter reaches STABLE_CNT-1. Go to DONE with res_data=dp_loop_out and res_timeout=0.
- Timeout: iteration counter == MAX_ITER. Go to DONE with res_data=dp_loop_out and res_timeout=1.
- Convergence and timeout in the same cycle: convergence wins, res_timeout=0.

DONE
- res_valid=1. res_data, res_timeout and res_iter stay stable until res_ready.
- On res_valid & res_ready: res_valid drops next cycle, go to IDLE, dp_clr_n returns to 0.
- req_valid is ignored outside IDLE.
- A new request accepted in IDLE the cycle after the handshake is legal: back-to-back throughput.

Arithmetic
- Counters saturate and never wrap.
- No floating-point math inside the block. Gain constants are hard-coded IEEE-754 singles.

Test Plan:
1. Reset mid-RUN (req_value=400) → all outputs return to reset values within the same cycle; after release, req_ready=1 and no res_valid.
2. req_value=36 → dp_gain=0x43870000, res_valid=1 two cycles after acceptance, res_data=0x40C00000, res_iter=0, dp_clr_n never released.
3. req_value=100 with a model whose dp_loop_out settles to 0x41200000 after 20 cycles (STABLE_CNT=8) → FLUSH lasts 4 cycles, res_data=0x41200000, res_timeout=0, res_iter=27.
4. req_value=2500 with dp_loop_out toggling every cycle, MAX_ITER=1023 → dp_gain=0x41200000, res_timeout=1, res_iter=1023.
5. Convergence reached exactly at iteration MAX_ITER → res_timeout=0.
6. res_ready held low for 50 cycles in DONE while req_valid=1 and the bench changes dp_loop_out → res_data stable and req_ready=0 throughout. Then res_ready=1 plus a second request (600, gain 0x42480000) → accepted on the first IDLE cycle.
